// File: rtl/sat_search_ctrl_pkg.sv
// rtl/sat_search_ctrl_pkg.sv - shared types and constants for the 3SAT search sequencer
package sat_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } sat_state_e;

  // Settle counter width for a given LAT; never narrower than one bit.
  function automatic int lat_cnt_w(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

  localparam int LAT_DEFAULT       = 0;
  localparam int LAT_CNT_W_DEFAULT = lat_cnt_w(LAT_DEFAULT);

endpackage

// File: rtl/sat_search_ctrl_if.sv
// rtl/sat_search_ctrl_if.sv - host and PLA-facing signal bundle of the search sequencer
interface sat_search_ctrl_if #(
  parameter int N = 10
);
  logic         start;
  logic         abort;
  logic         sat_in;
  logic [N-1:0] assign_out;
  logic         busy;
  logic         done;
  logic         found;
  logic [N-1:0] solution;
  logic [N:0]   sol_count;

  modport master (
    output start, abort, sat_in,
    input  assign_out, busy, done, found, solution, sol_count
  );

  modport slave (
    input  start, abort, sat_in,
    output assign_out, busy, done, found, solution, sol_count
  );
endinterface

// File: rtl/sat_search_ctrl_cand_counter.sv
// rtl/sat_search_ctrl_cand_counter.sv - N-bit candidate register with clear, increment and last flag
module sat_cand_counter #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [N-1:0] o_q,
  output logic         o_is_last
);
  logic [N-1:0] r_q;

  // Clear has priority so a restart never sees a stale increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_inc) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q       = r_q;
  assign o_is_last = &r_q;
endmodule

// File: rtl/sat_search_ctrl.sv
// rtl/sat_search_ctrl.sv - brute-force 3SAT search sequencer driving the clause PLA
// Optional macro SAT_SEARCH_COUNT_ALL_EN: keep searching after a hit and count every solution.
module sat_search_ctrl
  import sat_pkg::*;
#(
  parameter int N   = 10,
  parameter int LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  sat_search_ctrl_if.slave bus
);
  localparam int            CW    = lat_cnt_w(LAT);
  localparam logic [CW-1:0] LAT_C = CW'(LAT);

`ifdef SAT_SEARCH_COUNT_ALL_EN
  localparam bit COUNT_ALL = 1'b1;
`else
  localparam bit COUNT_ALL = 1'b0;
`endif

  sat_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic         r_busy;
  logic         r_done;
  logic         r_found;
  logic [N-1:0] r_solution;
  logic [N:0]   r_sol_count;

  logic         w_sample;
  logic         w_clr;
  logic         w_inc;
  logic         w_is_last;
  logic [N-1:0] w_cand;

  assign w_sample = (r_state == EVAL) && (r_cnt == LAT_C);
  assign w_clr    = !bus.abort && bus.start && (r_state != EVAL);
  // A hit only stops the walk when counting all solutions is disabled.
  assign w_inc    = !bus.abort && w_sample && !w_is_last && (COUNT_ALL || !bus.sat_in);

  sat_cand_counter #(
    .N (N)
  ) u_cand (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_inc     (w_inc),
    .o_q       (w_cand),
    .o_is_last (w_is_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_found     <= 1'b0;
      r_solution  <= '0;
      r_sol_count <= '0;
    end else if (bus.abort) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_found <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_state     <= EVAL;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_found     <= 1'b0;
            r_sol_count <= '0;
          end
        end
        EVAL: begin
          if (!w_sample) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt <= '0;
            if (bus.sat_in) begin
              r_sol_count <= r_sol_count + 1'b1;
              if (!r_found) begin
                r_solution <= w_cand;
                r_found    <= 1'b1;
              end
            end
            if ((bus.sat_in && !COUNT_ALL) || w_is_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.assign_out = w_cand;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.found      = r_found;
  assign bus.solution   = r_solution;
  assign bus.sol_count  = r_sol_count;
endmodule

// File: tb/tb_sat_search_ctrl.sv
// tb/tb_sat_search_ctrl.sv - self-checking bench for sat_search_ctrl with LAT=0 and LAT=2 instances
module tb_sat_search_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] mask = 8'h00;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sat_search_ctrl_if #(.N(3)) if0 ();
  sat_search_ctrl_if #(.N(3)) if2 ();

  assign if0.start  = start;
  assign if0.abort  = abort;
  assign if0.sat_in = mask[if0.assign_out];
  assign if2.start  = start;
  assign if2.abort  = abort;
  assign if2.sat_in = mask[if2.assign_out];

  sat_search_ctrl #(.N(3), .LAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  sat_search_ctrl #(.N(3), .LAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  typedef struct {
    logic [7:0] mask;
    bit         found;
    int         sol;
    int         cyc;
    int         cnt;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: scan the truth table of the instance as a set of satisfying assignments.
  function automatic void model(input logic [7:0] m, input int lat, output bit f,
                                output int sol, output int cyc, output int cnt);
    f   = (m != 8'h00);
    sol = 0;
    for (int k = 7; k >= 0; k--) if (m[k]) sol = k;
`ifdef SAT_SEARCH_COUNT_ALL_EN
    cnt = $countones(m);
    cyc = 8 * (lat + 1);
`else
    cnt = f ? 1 : 0;
    cyc = f ? (sol + 1) * (lat + 1) : 8 * (lat + 1);
`endif
  endfunction

  task automatic do_search(input logic [7:0] m, output int c0, output int c2);
    mask = m;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    c0 = -1;
    c2 = -1;
    for (int n = 1; n <= 100 && (c0 < 0 || c2 < 0); n++) begin
      @(negedge clk);
      if (c0 < 0 && if0.done) c0 = n;
      if (c2 < 0 && if2.done) c2 = n;
    end
  endtask

  task automatic check_dut(input string tag, input int cyc, input bit f, input int sol,
                           input int ecyc, input int cnt, input logic ofound,
                           input logic [2:0] osol, input logic [3:0] ocnt,
                           input logic obusy, input logic [2:0] oao);
    chk({tag, " cycles"}, cyc, ecyc);
    chk({tag, " found"}, ofound, f);
    if (f) chk({tag, " solution"}, osol, sol);
    chk({tag, " sol_count"}, ocnt, cnt);
    chk({tag, " busy"}, obusy, 0);
    if (!f) chk({tag, " assign_out"}, oao, 7);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " ao0"}, if0.assign_out, 0);
    chk({tag, " busy0"}, if0.busy, 0);
    chk({tag, " done0"}, if0.done, 0);
    chk({tag, " found0"}, if0.found, 0);
    chk({tag, " sol0"}, if0.solution, 0);
    chk({tag, " cnt0"}, if0.sol_count, 0);
    chk({tag, " ao2"}, if2.assign_out, 0);
    chk({tag, " busy2"}, if2.busy, 0);
    chk({tag, " done2"}, if2.done, 0);
    chk({tag, " sol2"}, if2.solution, 0);
  endtask

  initial begin
    int  c0, c2, sol, cyc, cnt;
    bit  f;

`ifdef SAT_SEARCH_COUNT_ALL_EN
    tbl[0] = '{8'h20, 1'b1, 5, 8, 1};
    tbl[1] = '{8'h00, 1'b0, 0, 8, 0};
    tbl[2] = '{8'h01, 1'b1, 0, 8, 1};
    tbl[3] = '{8'h01, 1'b1, 0, 8, 1};
    tbl[4] = '{8'h64, 1'b1, 2, 8, 3};
    tbl[5] = '{8'h80, 1'b1, 7, 8, 1};
    tbl[6] = '{8'hFF, 1'b1, 0, 8, 8};
`else
    tbl[0] = '{8'h20, 1'b1, 5, 6, 1};
    tbl[1] = '{8'h00, 1'b0, 0, 8, 0};
    tbl[2] = '{8'h01, 1'b1, 0, 1, 1};
    tbl[3] = '{8'h01, 1'b1, 0, 1, 1};
    tbl[4] = '{8'h64, 1'b1, 2, 3, 1};
    tbl[5] = '{8'h80, 1'b1, 7, 8, 1};
    tbl[6] = '{8'hFF, 1'b1, 0, 1, 1};
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_search(tbl[i].mask, c0, c2);
      check_dut($sformatf("tbl%0d lat0", i), c0, tbl[i].found, tbl[i].sol, tbl[i].cyc,
                tbl[i].cnt, if0.found, if0.solution, if0.sol_count, if0.busy, if0.assign_out);
      model(tbl[i].mask, 2, f, sol, cyc, cnt);
      check_dut($sformatf("tbl%0d lat2", i), c2, f, sol, cyc, cnt,
                if2.found, if2.solution, if2.sol_count, if2.busy, if2.assign_out);
    end

    // Exhausted search: candidate stays parked at all-ones while DONE is held.
    do_search(8'h00, c0, c2);
    repeat (3) @(negedge clk);
    chk("exhaust hold ao0", if0.assign_out, 7);
    chk("exhaust hold ao2", if2.assign_out, 7);
    chk("exhaust hold done0", if0.done, 1);

    for (int i = 0; i < 10; i++) begin
      logic [7:0] m;
      m = 8'($urandom_range(0, 255));
      do_search(m, c0, c2);
      model(m, 0, f, sol, cyc, cnt);
      check_dut($sformatf("rnd%0d lat0 m=%0h", i, m), c0, f, sol, cyc, cnt,
                if0.found, if0.solution, if0.sol_count, if0.busy, if0.assign_out);
      model(m, 2, f, sol, cyc, cnt);
      check_dut($sformatf("rnd%0d lat2 m=%0h", i, m), c2, f, sol, cyc, cnt,
                if2.found, if2.solution, if2.sol_count, if2.busy, if2.assign_out);
    end

    // Start during EVAL is ignored; abort together with start returns to IDLE.
    mask = 8'h00;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("eval start ignored ao", if0.assign_out, 2);
    chk("eval busy", if0.busy, 1);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort busy0", if0.busy, 0);
    chk("abort done0", if0.done, 0);
    chk("abort found0", if0.found, 0);
    chk("abort busy2", if2.busy, 0);
    repeat (2) @(negedge clk);
    chk("abort idle ao", if0.assign_out, 2);
    chk("abort idle busy", if0.busy, 0);

    // Hit on the sample cycle coinciding with abort is discarded.
    mask = 8'h01;
    @(negedge clk) start = 1'b1;
    @(negedge clk) begin start = 1'b0; abort = 1'b1; end
    @(negedge clk) abort = 1'b0;
    chk("hit+abort done", if0.done, 0);
    chk("hit+abort found", if0.found, 0);
    chk("hit+abort busy", if0.busy, 0);
    repeat (3) @(negedge clk);
    chk("hit+abort stays idle", if0.done, 0);

    // Asynchronous reset in the middle of a search.
    do_search(8'h80, c0, c2);
    mask = 8'h00;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post reset busy", if0.busy, 0);
    chk("post reset done", if0.done, 0);
    chk("post reset ao", if0.assign_out, 0);
    chk("post reset ao2", if2.assign_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
